mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 25 ++
 rtl/mem_responder_ram_sync.sv | 34 +++
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus commands, I/O map, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_responder_pkg;

    localparam int DEPTH = 256;
    localparam int WIDTH = 16;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        M_NONE  = 2'b00,
        M_READ  = 2'b01,
        M_WRITE = 2'b10,
        M_RSVD  = 2'b11
    } mem_cmd_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_responder_ram_sync.sv
// Single-port-write, registered-read RAM holding program and data words.
// Latency: read data appears one edge after re; writes land on the edge.
// Backpressure: none; one access per cycle on each port, always accepted.
module mem_responder_ram_sync #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: contents are never reset so a re-boot can skip reloading.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register only moves on a read, so it holds otherwise.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: boot loader phase, then CPU reads/writes to RAM and LED/switch I/O.
// Latency: reads return one edge after the command is sampled; writes commit on that edge.
// Backpressure: none; the CPU is held via cpu_hold during BOOT, afterwards one command per cycle.
module mem_responder
    import mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    input  logic        ld_we,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic        ld_done,
    output logic        cpu_hold,
    input  logic [7:0]  sw,
    output logic [7:0]  leds,
    output logic        bus_err
);

    state_t           state;
    mem_cmd_t         cmd;
    logic             ram_hit;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_re;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] io_rdata;
    logic             rd_from_ram;
    logic [7:0]       sw_meta;
    logic [7:0]       sw_sync;

    assign cmd     = mem_cmd_t'(mem_cmd);
    assign ram_hit = ~mem_addr[8];

    // RAM port steering: the loader owns the write port in BOOT, the CPU in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = mem_addr[7:0];
        ram_wdata = write_data;
        ram_re    = 1'b0;
        if (!reset) begin
            if (state == BOOT) begin
                ram_we    = ld_we;
                ram_waddr = ld_addr;
                ram_wdata = ld_data;
            end else begin
                ram_we = (cmd == M_WRITE) && ram_hit;
                ram_re = (cmd == M_READ) && ram_hit;
            end
        end
    end

    mem_responder_ram_sync #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (mem_addr[7:0]),
        .rdata (ram_rdata)
    );

    // Two-flop synchroniser for the board switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Boot/run FSM plus I/O registers, read-source select and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            cpu_hold    <= 1'b1;
            leds        <= '0;
            bus_err     <= 1'b0;
            io_rdata    <= '0;
            rd_from_ram <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (ld_done) begin
                        state    <= RUN;
                        cpu_hold <= 1'b0;
                    end
                end
                RUN: begin
                    case (cmd)
                        M_READ: begin
                            if (ram_hit) begin
                                rd_from_ram <= 1'b1;
                            end else begin
                                rd_from_ram <= 1'b0;
                                if (mem_addr == SW_ADDR) begin
                                    io_rdata <= {8'h00, sw_sync};
                                end else if (mem_addr == LED_ADDR) begin
                                    io_rdata <= {8'h00, leds};
                                end else begin
                                    io_rdata <= '0;
                                    bus_err  <= 1'b1;
                                end
                            end
                        end
                        M_WRITE: begin
                            if (!ram_hit) begin
                                if (mem_addr == LED_ADDR) begin
                                    leds <= write_data[7:0];
                                end else begin
                                    bus_err <= 1'b1;
                                end
                            end
                        end
                        M_RSVD: begin
                            bus_err <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // The last read's source decides which holding register drives the CPU.
    assign read_data = rd_from_ram ? ram_rdata : io_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed scenarios followed by randomized traffic.
// Expected outputs per edge come from an abstract memory/I/O model.
// A negedge monitor pops and compares them independently of the stimulus.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_done;
    logic        cpu_hold;
    logic [7:0]  sw;
    logic [7:0]  leds;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_done    (ld_done),
        .cpu_hold   (cpu_hold),
        .sw         (sw),
        .leds       (leds),
        .bus_err    (bus_err)
    );

    typedef struct {
        int          cyc;
        logic [15:0] rd;
        logic [7:0]  leds;
        logic        err;
        logic        hold;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model state
    logic [15:0] m_mem [256];
    logic [7:0]  m_leds;
    logic        m_err;
    logic        m_boot;
    logic [15:0] m_rd;
    logic [7:0]  sw_at  [4096];
    bit          rst_at [4096];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare every expected snapshot on the negedge following its edge.
    exp_t e_mon;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_check cyc=%0d got=none exp=cyc%0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e_mon = q.pop_front();
            chk("read_data", read_data, e_mon.rd);
            chk("leds", {8'h00, leds}, {8'h00, e_mon.leds});
            chk("bus_err", {15'h0, bus_err}, {15'h0, e_mon.err});
            chk("cpu_hold", {15'h0, cpu_hold}, {15'h0, e_mon.hold});
        end
    end

    // Switch value seen by the CPU at edge n: switches sampled two edges earlier,
    // forced to zero when a reset occurred on either of the two preceding edges.
    function automatic logic [7:0] sw_seen(input int n);
        if (n < 3) return 8'h00;
        if (rst_at[n-1] || rst_at[n-2]) return 8'h00;
        return sw_at[n-2];
    endfunction

    task automatic model(input int n);
        if (reset) begin
            m_boot = 1'b1;
            m_leds = 8'h00;
            m_err  = 1'b0;
            m_rd   = 16'h0000;
        end else if (m_boot) begin
            if (ld_we) m_mem[ld_addr] = ld_data;
            if (ld_done) m_boot = 1'b0;
        end else begin
            case (mem_cmd)
                2'b01: begin
                    if (!mem_addr[8])            m_rd = m_mem[mem_addr[7:0]];
                    else if (mem_addr == 9'h140) m_rd = {8'h00, sw_seen(n)};
                    else if (mem_addr == 9'h100) m_rd = {8'h00, m_leds};
                    else begin
                        m_rd  = 16'h0000;
                        m_err = 1'b1;
                    end
                end
                2'b10: begin
                    if (!mem_addr[8])            m_mem[mem_addr[7:0]] = write_data;
                    else if (mem_addr == 9'h100) m_leds = write_data[7:0];
                    else                         m_err = 1'b1;
                end
                2'b11: m_err = 1'b1;
                default: ;
            endcase
        end
    endtask

    // Apply current inputs for one edge and queue the expected outcome.
    task automatic step();
        int   n;
        exp_t e;
        n = cyc + 1;
        sw_at[n]  = sw;
        rst_at[n] = reset;
        model(n);
        e.cyc  = n;
        e.rd   = m_rd;
        e.leds = m_leds;
        e.err  = m_err;
        e.hold = m_boot;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic cmd_op(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        step();
        mem_cmd    = 2'b00;
    endtask

    initial begin
        reset = 1'b1; mem_cmd = 2'b00; mem_addr = '0; write_data = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0; sw = 8'h00;
        m_boot = 1'b1; m_leds = 8'h00; m_err = 1'b0; m_rd = 16'h0000;
        for (int i = 0; i < 4096; i++) begin
            sw_at[i]  = 8'h00;
            rst_at[i] = 1'b0;
        end
        #1;
        idle(2);
        reset = 1'b0;

        // Boot load: fill the whole RAM, with known words at 5 and 6
        for (int i = 0; i < 256; i++) begin
            ld_we   = 1'b1;
            ld_addr = 8'(i);
            ld_data = (i == 5) ? 16'h1234 : (i == 6) ? 16'hBEEF : 16'($urandom);
            step();
        end
        ld_we = 1'b0;
        cmd_op(2'b01, 9'h005, 16'h0);   // ignored in BOOT
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;

        cmd_op(2'b01, 9'h005, 16'h0);
        cmd_op(2'b01, 9'h006, 16'h0);

        cmd_op(2'b10, 9'h100, 16'h00A5);
        cmd_op(2'b01, 9'h100, 16'h0);
        cmd_op(2'b10, 9'h100, 16'hFF3C);

        sw = 8'h5A;
        idle(3);
        cmd_op(2'b01, 9'h140, 16'h0);

        cmd_op(2'b10, 9'h020, 16'h7777);
        cmd_op(2'b01, 9'h020, 16'h0);
        idle(3);

        cmd_op(2'b01, 9'h1FF, 16'h0);
        cmd_op(2'b10, 9'h140, 16'h0001);
        cmd_op(2'b11, 9'h020, 16'hDEAD);

        // Reset mid-RUN, BOOT-time reads ignored, RAM preserved
        cmd_op(2'b10, 9'h100, 16'h0077);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmd_op(2'b01, 9'h005, 16'h0);
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        cmd_op(2'b01, 9'h005, 16'h0);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            int       r;
            logic [8:0] a;
            r     = $urandom_range(0, 199);
            reset = (r == 0);
            if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
            ld_we   = ($urandom_range(0, 1) == 1) && !reset;
            ld_addr = 8'($urandom_range(0, 15));
            ld_data = 16'($urandom);
            ld_done = m_boot ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 5))
                0, 1, 2: a = {1'b0, 8'($urandom_range(0, 15))};
                3:       a = 9'h100;
                4:       a = 9'h140;
                default: begin
                    a = {1'b1, 8'($urandom)};
                    if (a == 9'h100 || a == 9'h140) a = 9'h1FF;
                end
            endcase
            mem_cmd    = 2'($urandom_range(0, 3));
            mem_addr   = a;
            write_data = 16'($urandom);
            step();
        end

        reset = 1'b0; mem_cmd = 2'b00; ld_we = 1'b0; ld_done = 1'b0;
        idle(2);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
